// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with a double-buffered display value.
// A load writes the shadow register; the shadow is committed to the display
// register only at a frame boundary, so a frame never shows mixed values.
module seg_scan #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*N_DIGITS-1:0]   i_value,
    input  logic                    i_minus,
    input  logic [N_DIGITS-1:0]     i_dp,
    output logic [7:0]              o_seg,
    output logic [N_DIGITS-1:0]     o_an,
    output logic                    o_frame
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0]       CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]          G_MINUS  = 7'b0000001;

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;

    logic [4*N_DIGITS-1:0]  sh_value;
    logic                   sh_minus;
    logic [N_DIGITS-1:0]    sh_dp;
    logic                   pending;

    logic [4*N_DIGITS-1:0]  dis_value;
    logic                   dis_minus;
    logic [N_DIGITS-1:0]    dis_dp;

    logic                   terminal;
    logic                   boundary;

    logic [N_DIGITS-1:0]    zero_run;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [6:0]             cur_glyph;
    logic [7:0]             seg_hi;
    logic [N_DIGITS-1:0]    an_hi;

    // Active-high a..g pattern for a hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    assign terminal = (cnt == CNT_LAST);
    assign boundary = terminal && (idx == IDX_LAST);

    // Leading-zero detection: digit k is in a zero run when every nibble from k
    // upward is zero; with minus set the top digit is ignored since it shows '-'.
    always_comb begin
        zero_run = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            logic acc;
            acc = 1'b1;
            for (int unsigned j = 0; j < N_DIGITS; j++) begin
                if (j >= k && !(dis_minus && j == N_DIGITS - 1) &&
                    dis_value[4*j +: 4] != 4'd0)
                    acc = 1'b0;
            end
            zero_run[k] = acc;
        end
    end

    // Select the current digit's glyph, dp and anode from the display register.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_hi     = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = dis_value[4*k +: 4];
                cur_dp    = dis_dp[k];
                cur_blank = (LZ_SUPPRESS != 0) && (k != 0) && zero_run[k];
                if (cnt != '0)
                    an_hi[k] = 1'b1;
            end
        end
        if (dis_minus && idx == IDX_LAST)
            cur_glyph = G_MINUS;
        else if (cur_blank)
            cur_glyph = '0;
        else
            cur_glyph = glyph(cur_nib);
        seg_hi = {cur_glyph, cur_dp};
    end

    // Scan counters, shadow capture and frame-boundary commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            idx       <= '0;
            sh_value  <= '0;
            sh_minus  <= 1'b0;
            sh_dp     <= '0;
            pending   <= 1'b0;
            dis_value <= '0;
            dis_minus <= 1'b0;
            dis_dp    <= '0;
        end else begin
            if (terminal) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Commit reads the pre-load shadow; a coincident load re-arms pending
            // because its assignment comes last.
            if (boundary && pending) begin
                dis_value <= sh_value;
                dis_minus <= sh_minus;
                dis_dp    <= sh_dp;
                pending   <= 1'b0;
            end
            if (i_load) begin
                sh_value <= i_value;
                sh_minus <= i_minus;
                sh_dp    <= i_dp;
                pending  <= 1'b1;
            end
        end
    end

    // Registered outputs with polarity applied; XOR with the off level inverts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_seg   <= SEG_OFF;
            o_an    <= AN_OFF;
            o_frame <= 1'b0;
        end else begin
            o_seg   <= seg_hi ^ SEG_OFF;
            o_an    <= an_hi ^ AN_OFF;
            o_frame <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: two instances (active-low without blanking,
// active-high with blanking) share stimulus; a frame-level reference model
// predicts each cycle's outputs and a monitor compares them after each edge.
module tb_seg_scan;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int DN = N * D;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [15:0] val = '0;
    logic        mn  = 1'b0;
    logic [3:0]  dp  = '0;

    logic [7:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        fr0, fr1;

    always #5 clk = ~clk;

    seg_scan #(.N_DIGITS(N), .SCAN_DIV(D), .ACTIVE_LOW(1), .LZ_SUPPRESS(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load(ld), .i_value(val), .i_minus(mn),
        .i_dp(dp), .o_seg(seg0), .o_an(an0), .o_frame(fr0)
    );

    seg_scan #(.N_DIGITS(N), .SCAN_DIV(D), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) u_dut_lz (
        .i_clk(clk), .i_rst(rst), .i_load(ld), .i_value(val), .i_minus(mn),
        .i_dp(dp), .o_seg(seg1), .o_an(an1), .o_frame(fr1)
    );

    typedef struct {
        int          t;
        logic [15:0] v;
        logic        m;
        logic [3:0]  d;
    } load_t;

    typedef struct {
        int          t;
        logic [7:0]  seg0;
        logic [3:0]  an0;
        logic        fr;
        logic [7:0]  seg1;
        logic [3:0]  an1;
    } exp_t;

    load_t lq[$];
    exp_t  eq[$];
    int    checks = 0;
    int    errors = 0;
    int    t = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v, input int tt);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0d: got %0h, expected %0h", nm, tt, act, exp_v);
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_seg0"}, seg0, 8'hFF, t);
        chk({nm, "_an0"},  an0,  4'hF,  t);
        chk({nm, "_fr0"},  fr0,  1'b0,  t);
        chk({nm, "_seg1"}, seg1, 8'h00, t);
        chk({nm, "_an1"},  an1,  4'h0,  t);
        chk({nm, "_fr1"},  fr1,  1'b0,  t);
    endtask

    // Outputs after the edge that consumes scan step tt. The value on screen in
    // a frame is the newest load issued before that frame's opening boundary step.
    function automatic exp_t model(input int tt);
        exp_t        e;
        logic [15:0] v;
        logic        m;
        logic [3:0]  d;
        logic [3:0]  nib;
        logic [6:0]  g_plain, g_lz;
        logic        allz;
        logic [3:0]  an_hi;
        int          slot, cnt, fstart, top;
        cnt    = tt % D;
        slot   = (tt / D) % N;
        fstart = (tt / DN) * DN;
        v = '0; m = 1'b0; d = '0;
        foreach (lq[i]) begin
            if (lq[i].t < fstart - 1) begin
                v = lq[i].v; m = lq[i].m; d = lq[i].d;
            end
        end
        nib  = v[slot*4 +: 4];
        top  = m ? N - 2 : N - 1;
        allz = 1'b1;
        for (int j = slot; j <= top; j++)
            if (v[j*4 +: 4] != 4'd0) allz = 1'b0;
        if (m && slot == N - 1) begin
            g_plain = 7'b0000001;
            g_lz    = 7'b0000001;
        end else begin
            g_plain = GLYPH[nib];
            g_lz    = (slot > 0 && allz) ? 7'b0000000 : GLYPH[nib];
        end
        an_hi  = (cnt == 0) ? 4'b0000 : 4'(1 << slot);
        e.t    = tt;
        e.seg0 = ~{g_plain, d[slot]};
        e.an0  = ~an_hi;
        e.fr   = ((tt % DN) == DN - 1);
        e.seg1 = {g_lz, d[slot]};
        e.an1  = an_hi;
        return e;
    endfunction

    // Called at a falling edge: drive one scan step, predict, wait one cycle.
    task automatic step(input logic l, input logic [15:0] v,
                        input logic m, input logic [3:0] d);
        load_t r;
        ld = l; val = v; mn = m; dp = d;
        if (l) begin
            r.t = t; r.v = v; r.m = m; r.d = d;
            lq.push_back(r);
        end
        eq.push_back(model(t));
        t++;
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 16'($urandom), 1'($urandom), 4'($urandom));
    endtask

    task automatic async_reset(input string nm);
        ld = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle({nm, "_async"});
        repeat (2) @(negedge clk);
        check_idle({nm, "_hold"});
        rst = 1'b0;
        t = 0;
        lq.delete();
        check_idle({nm, "_release"});
    endtask

    // Monitor: after every rising edge, compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("seg_al",   seg0, e.seg0, e.t);
                chk("an_al",    an0,  e.an0,  e.t);
                chk("frame_al", fr0,  e.fr,   e.t);
                chk("seg_lz",   seg1, e.seg1, e.t);
                chk("an_lz",    an1,  e.an1,  e.t);
                chk("frame_lz", fr1,  e.fr,   e.t);
            end
        end
    end

    initial begin
        logic [15:0] rv;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        t = 0;
        lq.delete();
        check_idle("release");

        // Mid-frame load, then a load one step before and one on a boundary.
        for (int i = 0; i < 80; i++) begin
            if (i == 5)       step(1'b1, 16'h1A2F, 1'b0, 4'b0100);
            else if (i == 30) step(1'b1, 16'h0050, 1'b1, 4'b0001);
            else if (i == 31) step(1'b1, 16'h0000, 1'b0, 4'b1010);
            else              idle_step();
        end

        // Pending load discarded by a reset landing in slot 2.
        for (int i = 0; i < 9; i++) begin
            if (i == 2) step(1'b1, 16'hBEEF, 1'b1, 4'hF);
            else        idle_step();
        end
        async_reset("pend");
        for (int i = 0; i < 40; i++) idle_step();

        // Random loads, biased toward zero nibbles to exercise blanking.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) async_reset("rand");
            if ($urandom_range(0, 15) == 0) begin
                rv = 16'($urandom);
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 1) == 0) rv[k*4 +: 4] = 4'h0;
                step(1'b1, rv, ($urandom_range(0, 3) == 0), 4'($urandom));
            end else begin
                idle_step();
            end
        end

        ld = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drain", 32'(eq.size()), 32'd0, t);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
